wb_master_bridge: RTL and testbench



---
 rtl/wb_master_bridge_pkg.sv | 18 +
 rtl/wb_master_bridge_if.sv | 26 ++
 rtl/wb_master_bridge_timeout_cnt.sv | 39 +++
 rtl/wb_master_bridge.sv | 149 ++++++++++++++
 tb/tb_wb_master_bridge.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_bridge_pkg.sv
// Shared types and helpers for the J1-to-Wishbone master bridge.
// Holds the FSM state encoding and the timeout counter width helper.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Counter must be able to hold TIMEOUT; a zero or one timeout still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// Wishbone classic pipelined bus bundle between the bridge (master) and an I/O slave.
interface wb_master_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack;
  logic          wb_stall;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    input  wb_dat_i, wb_ack, wb_stall
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    output wb_dat_i, wb_ack, wb_stall
  );

endinterface

// File: rtl/wb_master_bridge_timeout_cnt.sv
// Bus-cycle watchdog: counts cycles while a transfer is open and flags the
// cycle on which the count reaches TIMEOUT, so cyc stays high exactly TIMEOUT cycles.
module wb_timeout_cnt
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i & (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Turns single-beat J1 CPU I/O requests into Wishbone classic pipelined cycles,
// one transfer in flight, honouring stall and aborting on a missing ack.
module wb_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_i,
  output logic          cpu_ready_o,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [DW-1:0] cpu_wdat_i,
  output logic          cpu_rsp_o,
  output logic          cpu_err_o,
  output logic [DW-1:0] cpu_rdat_o,
  wb_master_bridge_if.master wb
);

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic          rsp_q, rsp_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdat_q, rdat_d;

  logic accept;
  logic taken;
  logic ack_ok;
  logic expired;
  logic cnt_clear;
  logic cnt_en;

  assign cpu_ready_o = (state_q == IDLE);
  assign accept      = cpu_req_i & cpu_ready_o;
  assign taken       = (state_q == REQ) & ~wb.wb_stall;
  // An ack only counts once the slave has actually taken the strobe.
  assign ack_ok      = wb.wb_ack & (taken | (state_q == WAIT));
  assign cnt_clear   = accept;
  assign cnt_en      = (state_q == REQ) | (state_q == WAIT);

  generate
    if (TIMEOUT > 0) begin : g_timeout
      wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
      ) u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_en),
        .expired_o (expired)
      );
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rsp_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = cpu_we_i;
          adr_d   = cpu_adr_i;
          wdat_d  = cpu_wdat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        if (taken) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
        // Ack beats a simultaneous timeout so late data is never thrown away.
        if (ack_ok) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rsp_d   = 1'b1;
          if (!we_q) begin
            rdat_d = wb.wb_dat_i;
          end
          state_d = IDLE;
        end else if (expired) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rsp_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rsp_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wb.wb_cyc   = cyc_q;
  assign wb.wb_stb   = stb_q;
  assign wb.wb_we    = we_q;
  assign wb.wb_adr   = adr_q;
  assign wb.wb_dat_o = wdat_q;
  assign cpu_rsp_o   = rsp_q;
  assign cpu_err_o   = err_q;
  assign cpu_rdat_o  = rdat_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with a behavioural Wishbone slave
// offering programmable stall, ack suppression and a forced late ack.
module tb_wb_master_bridge;

  logic        clk;
  logic        rstN;
  logic        cpuReq;
  logic        cpuReady;
  logic        cpuWe;
  logic [15:0] cpuAdr;
  logic [15:0] cpuWdat;
  logic        cpuRsp;
  logic        cpuErr;
  logic [15:0] cpuRdat;

  wb_master_bridge_if #(.AW(16), .DW(16)) bus ();

  wb_master_bridge #(
    .AW      (16),
    .DW      (16),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .cpu_req_i   (cpuReq),
    .cpu_ready_o (cpuReady),
    .cpu_we_i    (cpuWe),
    .cpu_adr_i   (cpuAdr),
    .cpu_wdat_i  (cpuWdat),
    .cpu_rsp_o   (cpuRsp),
    .cpu_err_o   (cpuErr),
    .cpu_rdat_o  (cpuRdat),
    .wb          (bus)
  );

  int testCount = 0;
  int failCount = 0;
  int cnt = 0;
  int acceptEdge = 0;
  int rspCount = 0;
  logic prevRsp = 1'b0;

  int stallCycles = 0;
  logic ackEnable = 1'b1;
  int raceAckCycle = 0;
  logic [15:0] slaveRdata = 16'h0000;
  int stallCnt = 0;
  logic ackPending = 1'b0;
  int slaveCycCount = 0;
  logic [15:0] slaveLog [8];
  int logCnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cnt++;

  assign bus.wb_dat_i = slaveRdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Slave decides this cycle's stall/ack on the falling edge so the bridge sees stable inputs.
  always @(negedge clk) begin
    if (!rstN || !bus.wb_cyc) begin
      bus.wb_stall = 1'b0;
      bus.wb_ack   = 1'b0;
      stallCnt     = 0;
      ackPending   = 1'b0;
      slaveCycCount = 0;
    end else begin
      slaveCycCount++;
      bus.wb_ack = (ackPending && ackEnable) || (slaveCycCount == raceAckCycle);
      ackPending = 1'b0;
      if (bus.wb_stb && stallCnt < stallCycles) begin
        bus.wb_stall = 1'b1;
        stallCnt++;
      end else begin
        bus.wb_stall = 1'b0;
        if (bus.wb_stb) begin
          ackPending = 1'b1;
          stallCnt   = 0;
          if (bus.wb_we && logCnt < 8) begin
            slaveLog[logCnt] = bus.wb_dat_o;
            logCnt++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cpuRsp) begin
      rspCount++;
      checkOutput("rspDouble", {31'b0, prevRsp}, 32'd0);
      checkOutput("cycLowAtRsp", {31'b0, bus.wb_cyc}, 32'd0);
    end
    prevRsp = cpuRsp;
  end

  task automatic waitReady();
    int i;
    i = 0;
    while (!cpuReady && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!cpuReady) checkOutput("readyTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] adr, input logic [15:0] wdat);
    cpuWe   = we;
    cpuAdr  = adr;
    cpuWdat = wdat;
    cpuReq  = 1'b1;
    waitReady();
    acceptEdge = cnt + 1;
    @(negedge clk);
    cpuReq = 1'b0;
  endtask

  task automatic waitRsp(output int lat, output int stbCnt, output int cycCnt,
                         output logic err, output logic [15:0] rdat);
    lat = 0; stbCnt = 0; cycCnt = 0; err = 1'b0; rdat = 16'h0;
    for (int i = 0; i < 100; i++) begin
      if (cpuRsp) begin
        lat  = cnt - acceptEdge + 1;
        err  = cpuErr;
        rdat = cpuRdat;
        break;
      end
      if (bus.wb_stb) stbCnt++;
      if (bus.wb_cyc) cycCnt++;
      @(negedge clk);
    end
    if (lat == 0) checkOutput("rspTimeout", 32'd0, 32'd1);
  endtask

  int lat, stbCnt, cycCnt, rspBefore, spurious;
  logic err;
  logic [15:0] rdat;
  int b2bEdge [4];

  initial begin
    rstN = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAdr = '0; cpuWdat = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstCyc",   {31'b0, bus.wb_cyc}, 32'd0);
    checkOutput("rstStb",   {31'b0, bus.wb_stb}, 32'd0);
    checkOutput("rstWe",    {31'b0, bus.wb_we}, 32'd0);
    checkOutput("rstAdr",   {16'b0, bus.wb_adr}, 32'd0);
    checkOutput("rstDat",   {16'b0, bus.wb_dat_o}, 32'd0);
    checkOutput("rstRsp",   {31'b0, cpuRsp}, 32'd0);
    checkOutput("rstErr",   {31'b0, cpuErr}, 32'd0);
    checkOutput("rstRdat",  {16'b0, cpuRdat}, 32'd0);
    checkOutput("rstReady", {31'b0, cpuReady}, 32'd1);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] zero-wait write");
    stallCycles = 0; ackEnable = 1'b1; logCnt = 0;
    applyStimulus(1'b1, 16'h0010, 16'hA5C3);
    checkOutput("wrCyc",   {31'b0, bus.wb_cyc}, 32'd1);
    checkOutput("wrStb",   {31'b0, bus.wb_stb}, 32'd1);
    checkOutput("wrWe",    {31'b0, bus.wb_we}, 32'd1);
    checkOutput("wrAdr",   {16'b0, bus.wb_adr}, 32'h0010);
    checkOutput("wrDat",   {16'b0, bus.wb_dat_o}, 32'hA5C3);
    checkOutput("wrReady", {31'b0, cpuReady}, 32'd0);
    waitRsp(lat, stbCnt, cycCnt, err, rdat);
    checkOutput("wrLat",    lat, 32'd3);
    checkOutput("wrStbCnt", stbCnt, 32'd1);
    checkOutput("wrErr",    {31'b0, err}, 32'd0);
    checkOutput("wrSlave",  {16'b0, slaveLog[0]}, 32'hA5C3);
    checkOutput("wrReadyAtRsp", {31'b0, cpuReady}, 32'd1);

    $display("[TB] read with 3 stall cycles");
    stallCycles = 3; slaveRdata = 16'h1234;
    applyStimulus(1'b0, 16'h0012, 16'h0000);
    waitRsp(lat, stbCnt, cycCnt, err, rdat);
    checkOutput("rdLat",    lat, 32'd6);
    checkOutput("rdStbCnt", stbCnt, 32'd4);
    checkOutput("rdErr",    {31'b0, err}, 32'd0);
    checkOutput("rdData",   {16'b0, rdat}, 32'h1234);
    stallCycles = 0;
    @(negedge clk);
    checkOutput("rdHold",   {16'b0, cpuRdat}, 32'h1234);

    $display("[TB] back-to-back writes");
    logCnt = 0; rspBefore = rspCount;
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAdr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      cpuWdat = 16'(i + 1);
      waitReady();
      b2bEdge[i] = cnt + 1;
      @(negedge clk);
    end
    cpuReq = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    for (int i = 1; i < 4; i++) checkOutput("b2bSpacing", b2bEdge[i] - b2bEdge[i-1], 32'd3);
    for (int i = 0; i < 4; i++) checkOutput("b2bSlave", {16'b0, slaveLog[i]}, 32'(i + 1));
    checkOutput("b2bRspCount", rspCount - rspBefore, 32'd4);
    checkOutput("b2bAdr", {16'b0, bus.wb_adr}, 32'h0020);
    checkOutput("b2bRdatKept", {16'b0, cpuRdat}, 32'h1234);

    $display("[TB] timeout with silent slave");
    ackEnable = 1'b0; slaveRdata = 16'hBEEF;
    applyStimulus(1'b0, 16'h0030, 16'h0000);
    waitRsp(lat, stbCnt, cycCnt, err, rdat);
    checkOutput("toCycCnt", cycCnt, 32'd15);
    checkOutput("toLat",    lat, 32'd16);
    checkOutput("toErr",    {31'b0, err}, 32'd1);
    checkOutput("toRdat",   {16'b0, rdat}, 32'h1234);
    ackEnable = 1'b1; slaveRdata = 16'h5A5A;
    @(negedge clk);
    applyStimulus(1'b0, 16'h0032, 16'h0000);
    waitRsp(lat, stbCnt, cycCnt, err, rdat);
    checkOutput("afterToLat",  lat, 32'd3);
    checkOutput("afterToErr",  {31'b0, err}, 32'd0);
    checkOutput("afterToRdat", {16'b0, rdat}, 32'h5A5A);

    $display("[TB] ack on the timeout cycle");
    ackEnable = 1'b0; raceAckCycle = 15; slaveRdata = 16'h0F0F;
    @(negedge clk);
    applyStimulus(1'b0, 16'h0034, 16'h0000);
    waitRsp(lat, stbCnt, cycCnt, err, rdat);
    checkOutput("raceLat",  lat, 32'd16);
    checkOutput("raceErr",  {31'b0, err}, 32'd0);
    checkOutput("raceRdat", {16'b0, rdat}, 32'h0F0F);
    raceAckCycle = 0;

    $display("[TB] reset during WAIT");
    @(negedge clk);
    applyStimulus(1'b0, 16'h0036, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("midCycBefore", {31'b0, bus.wb_cyc}, 32'd1);
    checkOutput("midStbBefore", {31'b0, bus.wb_stb}, 32'd0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midCyc",   {31'b0, bus.wb_cyc}, 32'd0);
    checkOutput("midStb",   {31'b0, bus.wb_stb}, 32'd0);
    checkOutput("midReady", {31'b0, cpuReady}, 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpuRsp || !cpuReady) spurious++;
    end
    checkOutput("midSpurious", spurious, 32'd0);

    ackEnable = 1'b1; logCnt = 0;
    applyStimulus(1'b1, 16'h0040, 16'h1357);
    waitRsp(lat, stbCnt, cycCnt, err, rdat);
    checkOutput("recoverLat",   lat, 32'd3);
    checkOutput("recoverErr",   {31'b0, err}, 32'd0);
    checkOutput("recoverSlave", {16'b0, slaveLog[0]}, 32'h1357);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
